// File: rtl/fme_pkg.sv
// fme_pkg: shared pixel width, row geometry and feeder FSM states for the SAD tree datapath (no ports)
package fme_pkg;
    localparam int FME_DATAWIDTH = 8;
    localparam int FME_ROWS = 8;
    localparam int ORG_PIX = 8;
    localparam int CAND_PIX = 9;
    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} feeder_state_t;
endpackage

// File: rtl/sad_tree_feeder_row_unpack.sv
// row_unpack: splits a packed row (pixel 0 in LSBs) into pixel buses; row_i packed row in, px_o pixel array out
module row_unpack
    import fme_pkg::*;
#(
    parameter int N = ORG_PIX,
    parameter int W = FME_DATAWIDTH
) (
    input  logic [N*W-1:0] row_i,
    output logic [W-1:0]   px_o [N]
);
    for (genvar i = 0; i < N; i++) begin : g_px
        assign px_o[i] = row_i[i*W +: W];
    end
endmodule

// File: rtl/sad_tree_feeder.sv
// sad_tree_feeder: row sequencer feeding the 12-SAD tree; optional 2D right side under SAD_FEEDER_PVSO_EN
// ports: clock/reset (sync, active-high); start/pvso block request; in_valid/in_ready row handshake with
// org_row/a_row/b_row/c_row; registered pixel outputs original_*, original_ante_*, a*/b*/c*; tree controls
// enable_left_side/enable_right_side/enable_out/sel/reset_right_sads; busy and sad_done status
module sad_tree_feeder
    import fme_pkg::*;
#(
    parameter int DATAWIDTH = FME_DATAWIDTH,
    parameter int ROWS      = FME_ROWS,
    parameter int SAD_LAT   = 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          pvso,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [ORG_PIX*DATAWIDTH-1:0]  org_row,
    input  logic [CAND_PIX*DATAWIDTH-1:0] a_row,
    input  logic [CAND_PIX*DATAWIDTH-1:0] b_row,
    input  logic [CAND_PIX*DATAWIDTH-1:0] c_row,
    output logic [DATAWIDTH-1:0]          original_0, original_1, original_2, original_3,
    output logic [DATAWIDTH-1:0]          original_4, original_5, original_6, original_7,
    output logic [DATAWIDTH-1:0]          original_ante_0, original_ante_1, original_ante_2, original_ante_3,
    output logic [DATAWIDTH-1:0]          original_ante_4, original_ante_5, original_ante_6, original_ante_7,
    output logic [DATAWIDTH-1:0]          a0, a1, a2, a3, a4, a5, a6, a7, a8,
    output logic [DATAWIDTH-1:0]          b0, b1, b2, b3, b4, b5, b6, b7, b8,
    output logic [DATAWIDTH-1:0]          c0, c1, c2, c3, c4, c5, c6, c7, c8,
    output logic                          enable_left_side,
    output logic                          enable_right_side,
    output logic                          enable_out,
    output logic                          sel,
    output logic                          reset_right_sads,
    output logic                          busy,
    output logic                          sad_done
);
`ifdef SAD_FEEDER_PVSO_EN
    localparam bit PVSO_EN = 1'b1;
`else
    localparam bit PVSO_EN = 1'b0;
`endif
    localparam int CW = $clog2(ROWS + SAD_LAT + 3);
    localparam logic [CW-1:0] R_LAST = CW'(ROWS - 1);
    localparam logic [CW-1:0] R_END  = CW'(ROWS);
    // FLUSH exits on this count, so sad_done lands SAD_LAT+2 cycles after the last row's outputs
    localparam logic [CW-1:0] F_END  = CW'(SAD_LAT + 1);

    feeder_state_t                 state_q;
    logic [CW-1:0]                 cnt_q;
    logic                          pv_q;
    logic [ORG_PIX*DATAWIDTH-1:0]  org_q, ante_q;
    logic [CAND_PIX*DATAWIDTH-1:0] a_q, b_q, c_q;
    logic [DATAWIDTH-1:0]          org_px [ORG_PIX];
    logic [DATAWIDTH-1:0]          ante_px [ORG_PIX];
    logic [DATAWIDTH-1:0]          a_px [CAND_PIX];
    logic [DATAWIDTH-1:0]          b_px [CAND_PIX];
    logic [DATAWIDTH-1:0]          c_px [CAND_PIX];
    logic                          xfer_d, last_d;

    assign xfer_d = state_q == LOAD && in_valid && in_ready;
    assign last_d = cnt_q == (pv_q ? R_END : R_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q           <= IDLE;
            cnt_q             <= '0;
            pv_q              <= 1'b0;
            in_ready          <= 1'b0;
            busy              <= 1'b0;
            sad_done          <= 1'b0;
            enable_left_side  <= 1'b0;
            enable_right_side <= 1'b0;
            enable_out        <= 1'b0;
            sel               <= 1'b0;
            reset_right_sads  <= 1'b0;
            org_q             <= '0;
            ante_q            <= '0;
            a_q               <= '0;
            b_q               <= '0;
            c_q               <= '0;
        end else begin
            enable_left_side  <= 1'b0;
            enable_right_side <= 1'b0;
            enable_out        <= 1'b0;
            sel               <= 1'b0;
            reset_right_sads  <= 1'b0;
            sad_done          <= 1'b0;
            if (xfer_d) begin
                // row ROWS exists only in 2D mode and carries candidates only
                enable_left_side  <= cnt_q != R_END;
                enable_right_side <= pv_q && cnt_q != '0;
                sel               <= cnt_q == '0;
                enable_out        <= cnt_q == R_LAST;
                reset_right_sads  <= pv_q && cnt_q == '0;
                if (cnt_q != R_END) org_q <= org_row;
                ante_q            <= PVSO_EN ? org_q : '0;
                a_q               <= a_row;
                b_q               <= b_row;
                c_q               <= c_row;
            end
            case (state_q)
                IDLE: if (start) begin
                    state_q  <= LOAD;
                    cnt_q    <= '0;
                    pv_q     <= pvso && PVSO_EN;
                    in_ready <= 1'b1;
                    busy     <= 1'b1;
                end
                LOAD: if (xfer_d) begin
                    if (last_d) begin
                        state_q  <= FLUSH;
                        cnt_q    <= '0;
                        in_ready <= 1'b0;
                    end else cnt_q <= cnt_q + 1'b1;
                end
                FLUSH: if (cnt_q == F_END) begin
                    state_q  <= DONE;
                    cnt_q    <= '0;
                    sad_done <= 1'b1;
                end else cnt_q <= cnt_q + 1'b1;
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    row_unpack #(.N(ORG_PIX),  .W(DATAWIDTH)) u_org  (.row_i(org_q),  .px_o(org_px));
    row_unpack #(.N(ORG_PIX),  .W(DATAWIDTH)) u_ante (.row_i(ante_q), .px_o(ante_px));
    row_unpack #(.N(CAND_PIX), .W(DATAWIDTH)) u_a    (.row_i(a_q),    .px_o(a_px));
    row_unpack #(.N(CAND_PIX), .W(DATAWIDTH)) u_b    (.row_i(b_q),    .px_o(b_px));
    row_unpack #(.N(CAND_PIX), .W(DATAWIDTH)) u_c    (.row_i(c_q),    .px_o(c_px));

    assign original_0 = org_px[0];
    assign original_1 = org_px[1];
    assign original_2 = org_px[2];
    assign original_3 = org_px[3];
    assign original_4 = org_px[4];
    assign original_5 = org_px[5];
    assign original_6 = org_px[6];
    assign original_7 = org_px[7];
    assign original_ante_0 = ante_px[0];
    assign original_ante_1 = ante_px[1];
    assign original_ante_2 = ante_px[2];
    assign original_ante_3 = ante_px[3];
    assign original_ante_4 = ante_px[4];
    assign original_ante_5 = ante_px[5];
    assign original_ante_6 = ante_px[6];
    assign original_ante_7 = ante_px[7];
    assign a0 = a_px[0];
    assign a1 = a_px[1];
    assign a2 = a_px[2];
    assign a3 = a_px[3];
    assign a4 = a_px[4];
    assign a5 = a_px[5];
    assign a6 = a_px[6];
    assign a7 = a_px[7];
    assign a8 = a_px[8];
    assign b0 = b_px[0];
    assign b1 = b_px[1];
    assign b2 = b_px[2];
    assign b3 = b_px[3];
    assign b4 = b_px[4];
    assign b5 = b_px[5];
    assign b6 = b_px[6];
    assign b7 = b_px[7];
    assign b8 = b_px[8];
    assign c0 = c_px[0];
    assign c1 = c_px[1];
    assign c2 = c_px[2];
    assign c3 = c_px[3];
    assign c4 = c_px[4];
    assign c5 = c_px[5];
    assign c6 = c_px[6];
    assign c7 = c_px[7];
    assign c8 = c_px[8];
endmodule

// File: tb/tb_sad_tree_feeder.sv
// tb_sad_tree_feeder: directed scoreboard bench for sad_tree_feeder
module tb_sad_tree_feeder;
`ifdef SAD_FEEDER_PVSO_EN
    localparam bit PV_EN = 1'b1;
`else
    localparam bit PV_EN = 1'b0;
`endif
    typedef struct packed {
        logic [7:0] o0, o7, an0, a0, b4, c8;
        logic       l, r, s, eo, rr;
    } exp_t;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0, pvso = 1'b0, in_valid = 1'b0;
    logic [63:0] org_row = '0;
    logic [71:0] a_row = '0, b_row = '0, c_row = '0;
    logic in_ready, busy, sad_done, enable_left_side, enable_right_side, enable_out, sel, reset_right_sads;
    logic [7:0] original_0, original_1, original_2, original_3, original_4, original_5, original_6, original_7;
    logic [7:0] original_ante_0, original_ante_1, original_ante_2, original_ante_3;
    logic [7:0] original_ante_4, original_ante_5, original_ante_6, original_ante_7;
    logic [7:0] a0, a1, a2, a3, a4, a5, a6, a7, a8;
    logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7, b8;
    logic [7:0] c0, c1, c2, c3, c4, c5, c6, c7, c8;

    exp_t exq[$];
    logic [63:0] org_m = '0;
    logic [31:0] hold_v = '0;
    int checks = 0, passed = 0, cyc = 0, bid = 0;
    int n_sd = 0, n_sel = 0, n_eo = 0, n_rr = 0, n_l = 0, n_r = 0, n_en = 0;
    int b_sd, b_sel, b_eo, b_rr, b_l, b_r, b_en;
    int blk_first = -1, last_en = 0, sel_cyc = 0, sd_cyc = 0;

    sad_tree_feeder dut (
        .clock(clk), .reset(reset), .start(start), .pvso(pvso), .in_valid(in_valid), .in_ready(in_ready),
        .org_row(org_row), .a_row(a_row), .b_row(b_row), .c_row(c_row),
        .original_0(original_0), .original_1(original_1), .original_2(original_2), .original_3(original_3),
        .original_4(original_4), .original_5(original_5), .original_6(original_6), .original_7(original_7),
        .original_ante_0(original_ante_0), .original_ante_1(original_ante_1),
        .original_ante_2(original_ante_2), .original_ante_3(original_ante_3),
        .original_ante_4(original_ante_4), .original_ante_5(original_ante_5),
        .original_ante_6(original_ante_6), .original_ante_7(original_ante_7),
        .a0(a0), .a1(a1), .a2(a2), .a3(a3), .a4(a4), .a5(a5), .a6(a6), .a7(a7), .a8(a8),
        .b0(b0), .b1(b1), .b2(b2), .b3(b3), .b4(b4), .b5(b5), .b6(b6), .b7(b7), .b8(b8),
        .c0(c0), .c1(c1), .c2(c2), .c3(c3), .c4(c4), .c5(c5), .c6(c6), .c7(c7), .c8(c8),
        .enable_left_side(enable_left_side), .enable_right_side(enable_right_side),
        .enable_out(enable_out), .sel(sel), .reset_right_sads(reset_right_sads),
        .busy(busy), .sad_done(sad_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic observe();
        exp_t e;
        if ((enable_left_side | enable_right_side) === 1'b1) begin
            n_en++;
            if (blk_first < 0) blk_first = cyc;
            last_en = cyc;
            if (exq.size() == 0) chk("row_unexpected", 1, 0);
            else begin
                e = exq.pop_front();
                chk("row_ctrl", {enable_left_side, enable_right_side, sel, enable_out, reset_right_sads},
                    {e.l, e.r, e.s, e.eo, e.rr});
                chk("row_org", {original_0, original_7, original_ante_0}, {e.o0, e.o7, e.an0});
                chk("row_cand", {a0, b4, c8}, {e.a0, e.b4, e.c8});
                hold_v = {e.a0, e.c8, e.o0, e.an0};
            end
        end else if (busy === 1'b1) begin
            chk("idle_pulse", {sel, enable_out, reset_right_sads}, 3'b0);
            chk("hold", {a0, c8, original_0, original_ante_0}, hold_v);
        end
        if (sel === 1'b1) begin n_sel++; sel_cyc = cyc; end
        if (enable_out === 1'b1) n_eo++;
        if (reset_right_sads === 1'b1) n_rr++;
        if (enable_left_side === 1'b1) n_l++;
        if (enable_right_side === 1'b1) n_r++;
        if (sad_done === 1'b1) begin n_sd++; sd_cyc = cyc; end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        observe();
    endtask

    task automatic begin_blk();
        b_sd = n_sd; b_sel = n_sel; b_eo = n_eo; b_rr = n_rr; b_l = n_l; b_r = n_r; b_en = n_en;
        blk_first = -1;
        bid++;
    endtask

    task automatic drive_row(input int k, input bit pm);
        exp_t e;
        logic [63:0] prev;
        prev = org_m;
        for (int p = 0; p < 8; p++) org_row[p*8 +: 8] = 8'(bid * 37 + k * 8 + p);
        for (int p = 0; p < 9; p++) begin
            a_row[p*8 +: 8] = 8'(128 + bid * 11 + k * 9 + p);
            b_row[p*8 +: 8] = 8'(64 + bid * 5 + k * 9 + p);
            c_row[p*8 +: 8] = 8'(192 + bid * 3 + k * 9 + p);
        end
        if (k < 8) org_m = org_row;
        e.o0 = org_m[7:0];
        e.o7 = org_m[63:56];
        e.an0 = PV_EN ? prev[7:0] : 8'h00;
        e.a0 = a_row[7:0];
        e.b4 = b_row[39:32];
        e.c8 = c_row[71:64];
        e.l = k < 8;
        e.r = pm && k >= 1;
        e.s = k == 0;
        e.eo = k == 7;
        e.rr = pm && k == 0;
        exq.push_back(e);
    endtask

    task automatic feed(input bit pm, input int stall_at, input int stall_n, input int rst_at);
        int nrows = pm ? 9 : 8;
        int k = 0;
        int st = 0;
        int g = 0;
        while (k < nrows && g < 80) begin
            g++;
            if (st > 0) begin
                in_valid = 1'b0;
                st--;
            end else if (in_ready !== 1'b1) in_valid = 1'b0;
            else if (k == rst_at) begin
                reset = 1'b1;
                in_valid = 1'b1;
                step();
                reset = 1'b0;
                in_valid = 1'b0;
                org_m = '0;
                hold_v = '0;
                return;
            end else begin
                drive_row(k, pm);
                in_valid = 1'b1;
                if (k == stall_at) st = stall_n;
                k++;
            end
            step();
        end
        in_valid = 1'b0;
        if (k < nrows) chk("feed_timeout", k, nrows);
    endtask

    task automatic wait_done(input int lat, input bit pm, input int stall_n);
        int t = 0;
        while (n_sd == b_sd && t < 40) begin
            step();
            t++;
        end
        chk("done_seen", n_sd - b_sd, 1);
        chk("done_lat", sd_cyc - sel_cyc, lat);
        chk("n_sel", n_sel - b_sel, 1);
        chk("n_eout", n_eo - b_eo, 1);
        chk("n_rrs", n_rr - b_rr, pm ? 1 : 0);
        chk("n_left", n_l - b_l, 8);
        chk("n_right", n_r - b_r, pm ? 8 : 0);
        chk("stall_gap", last_en - blk_first + 1 - (n_en - b_en), stall_n);
        chk("q_empty", exq.size(), 0);
        step();
        chk("busy_drop", {busy, sad_done}, 2'b00);
    endtask

    task automatic run(input bit pv, input int stall_at, input int stall_n);
        bit pm = pv && PV_EN;
        begin_blk();
        start = 1'b1;
        pvso = pv;
        step();
        start = 1'b0;
        chk("busy_on", {busy, in_ready}, 2'b11);
        feed(pm, stall_at, stall_n, -1);
        wait_done((pm ? 11 : 10) + stall_n, pm, stall_n);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctrl"}, {in_ready, busy, sad_done, enable_left_side, enable_right_side,
            enable_out, sel, reset_right_sads}, 8'h00);
        chk({tag, "_pix"}, |{original_0, original_1, original_2, original_3, original_4, original_5,
            original_6, original_7, original_ante_0, original_ante_1, original_ante_2, original_ante_3,
            original_ante_4, original_ante_5, original_ante_6, original_ante_7,
            a0, a1, a2, a3, a4, a5, a6, a7, a8, b0, b1, b2, b3, b4, b5, b6, b7, b8,
            c0, c1, c2, c3, c4, c5, c6, c7, c8}, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk_zero("reset");
        run(1'b0, -1, 0);
        run(1'b1, -1, 0);
        run(1'b0, 3, 3);
        begin_blk();
        start = 1'b1;
        pvso = 1'b0;
        step();
        start = 1'b0;
        feed(1'b0, -1, 0, 5);
        chk_zero("midrst");
        chk("midrst_q", exq.size(), 0);
        run(1'b1, -1, 0);
        begin_blk();
        start = 1'b1;
        pvso = 1'b0;
        step();
        chk("held_busy_on", busy, 1'b1);
        feed(1'b0, -1, 0, -1);
        wait_done(10, 1'b0, 0);
        begin_blk();
        step();
        chk("held_restart", {busy, in_ready}, 2'b11);
        start = 1'b0;
        feed(1'b0, -1, 0, -1);
        wait_done(10, 1'b0, 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
